uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver and the next generation of the team's fixed 8N1 receiver. It supports configurable bit period, data width, parity mode and stop-bit count. It adds an input synchroniser, false-start rejection, and parity, framing and overrun error reporting. It sits between the board RX pin and the byte-consuming logic (command parser / RX FIFO) in the same clk domain.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (>= 8); default gives 115200 baud at 50 MHz.
DATA_BITS, 8, payload width, legal 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, legal 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  serial line, asynchronous, idle high
d_out  out  DATA_BITS  received word, LSB = first bit on line
rx_valid  out  1  one-cycle pulse: d_out and error flags are valid
rd_ack  in  1  consumer has taken current word; clears pending
parity_err  out  1  parity mismatch for the word flagged by rx_valid
frame_err  out  1  a stop bit sampled low
overrun_err  out  1  new word completed while previous was unacknowledged
busy  out  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset values (clk or reset edge):
  - All outputs 0.
  - Synchroniser flops 1.
  - FSM in IDLE; counters 0; pending flag 0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s. Add 2 cycles of latency to every rx-referenced timing below.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1. The "mid-sample" occurs at cnt == CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - rx_s == 0 -> START, cnt = 0, busy = 1.
- START:
  - At the mid-sample, rx_s == 1 -> IDLE (glitch rejected, no outputs, busy = 0).
  - rx_s == 0 at the mid-sample -> cnt restarts. From here every sample is one full bit period later (centre of each bit).
  - -> DATA.
- DATA:
  - Shift rx_s in LSB-first at each bit centre. Running parity accumulates by XOR.
  - After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Sample one bit.
  - Mismatch rule: for even, the XOR of data and parity bit must be 0; for odd, it must be 1. A mismatch latches a parity error for this frame.
- STOP:
  - Sample STOP_BITS bits. Any low sample latches a frame error.
  - On the last stop sample, the next clk edge does all of the following:
    - d_out <= shift reg, zero-extended to DATA_BITS.
    - rx_valid = 1 for exactly 1 cycle.
    - parity_err / frame_err reflect this frame and are held until the next rx_valid.
    - overrun_err = pending (pending set and not rd_ack this cycle).
    - pending <= 1.
  - Exit: -> IDLE if the last stop was 1; -> WAIT_IDLE if it was 0 (break / framing).
- WAIT_IDLE:
  - Stay until rx_s == 1, then -> IDLE.
  - Prevents a held-low line from retriggering as back-to-back 0x00 frames.
- busy = 0 in IDLE.
- rd_ack:
  - Clears pending.
  - rd_ack in the same cycle as rx_valid applies to the old word: no overrun, pending stays 1 for the new word.
  - rd_ack with pending = 0 is ignored.
- d_out is stable between rx_valid pulses. Overrun overwrites d_out; the old word is lost.
- Frame latency: rx_valid occurs 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT + 1 cycles after the rx falling edge, where P = (PARITY_MODE != 0).
- Reset mid-frame: immediate return to IDLE. The partial word is discarded and no rx_valid is produced.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each mid-sample (start, data, parity, stop) uses a 2-of-3 majority of rx_s at cnt = mid-1, mid, mid+1. The decision is made at mid+1; all timing above shifts by +1 cycle.
- Undefined: single sample at mid.
- The port list is identical in both builds.

Decomposition:
- Package uart_pkg:
  - FSM state enum (uart_rx_state_t).
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants.
  - Function computing the counter width, $clog2(CLKS_PER_BIT).
- Sub-module uart_sync2: 2-flop synchroniser with reset value 1, reusable by the TX loopback and other async inputs.
- The FSM, counters and error logic stay in one module.

Test Plan:
- 8N1, CLKS_PER_BIT=16: send 0xA5 -> one rx_valid, d_out = 0xA5, all errors 0, rx_valid 2+8+9*16+1 = 155 cycles after the start edge.
- PARITY_MODE=1, DATA_BITS=7: send 0x55 with correct parity, then 0x55 with the parity bit flipped -> parity_err 0 then 1, d_out = 0x55 both times.
- Glitch: rx low for 5 cycles (CLKS_PER_BIT=16) -> no rx_valid, busy returns to 0, next valid frame 0x3C received correctly.
- Stop bit low, then line held low 100 bit times -> single rx_valid with frame_err = 1, d_out = 0x00, FSM in WAIT_IDLE, no further rx_valid until rx returns high.
- Two frames 0x11, 0x22 with no rd_ack -> second rx_valid has overrun_err = 1, d_out = 0x22. Repeat with rd_ack pulsed between frames -> overrun_err = 0.
- Assert reset during DATA bit 4, release, send 0x7E -> no rx_valid for the aborted frame, then d_out = 0x7E. With UART_RX_MAJORITY_EN: a one-cycle inverted glitch at mid of bit 2 -> word still 0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver family.
package uart_pkg;

  typedef logic [2:0] uart_rx_state_t;

  localparam uart_rx_state_t ST_IDLE      = 3'd0;
  localparam uart_rx_state_t ST_START     = 3'd1;
  localparam uart_rx_state_t ST_DATA      = 3'd2;
  localparam uart_rx_state_t ST_PARITY    = 3'd3;
  localparam uart_rx_state_t ST_STOP      = 3'd4;
  localparam uart_rx_state_t ST_WAIT_IDLE = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_param_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset high (idle line level).
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection and parity/frame/overrun flags.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority around each bit centre (+1 cycle latency).
//
// state      | meaning
// IDLE       | line idle, waiting for a low level
// START      | start bit seen, confirming at its centre
// DATA       | sampling payload bits LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling stop bit(s), word delivered on the last one
// WAIT_IDLE  | last stop was low, waiting for the line to return high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_valid,
  input  logic                 rd_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int MID_OFS = 1;
`else
  localparam int MID_OFS = 0;
`endif
  localparam logic [CNT_W-1:0] MID_CNT   = CNT_W'(CLKS_PER_BIT / 2 + MID_OFS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_MODE == PARITY_ODD);

  logic rx_s;
  logic sample_bit;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from the two previous cycles; the vote is taken one cycle after centre.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d     = {hist_q[0], rx_s};
    sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end
`else
  assign sample_bit = rx_s;
`endif

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 pending_q, pending_d;
  logic [DATA_BITS-1:0] d_out_q, d_out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 at_mid, at_bit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    stop_idx_d    = stop_idx_q;
    shift_d       = shift_q;
    par_acc_d     = par_acc_q;
    perr_acc_d    = perr_acc_q;
    ferr_acc_d    = ferr_acc_q;
    pending_d     = pending_q;
    d_out_d       = d_out_q;
    rx_valid_d    = 1'b0;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;
    cnt_inc       = cnt_q + CNT_W'(1);
    at_mid        = (cnt_q == MID_CNT);
    at_bit        = (cnt_q == LAST_CNT);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (at_mid) begin
          cnt_d = '0;
          if (sample_bit) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            bit_idx_d  = '0;
            par_acc_d  = 1'b0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DATA: begin
        if (at_bit) begin
          cnt_d     = '0;
          shift_d   = {sample_bit, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ sample_bit;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_DATA) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PARITY: begin
        if (at_bit) begin
          cnt_d      = '0;
          perr_acc_d = par_acc_q ^ sample_bit ^ PAR_ODD;
          state_d    = ST_STOP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STOP: begin
        if (at_bit) begin
          cnt_d      = '0;
          stop_idx_d = stop_idx_q + 1'b1;
          if (!sample_bit) ferr_acc_d = 1'b1;
          if (stop_idx_q == STOP_LAST) begin
            d_out_d       = shift_q;
            rx_valid_d    = 1'b1;
            parity_err_d  = perr_acc_q;
            frame_err_d   = ferr_acc_q | ~sample_bit;
            overrun_err_d = pending_q & ~rd_ack;
            state_d       = sample_bit ? ST_IDLE : ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // An ack coinciding with a new word belongs to the old word, so the new one stays pending.
    if (rx_valid_d)  pending_d = 1'b1;
    else if (rd_ack) pending_d = 1'b0;

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
      shift_q       <= '0;
      par_acc_q     <= 1'b0;
      perr_acc_q    <= 1'b0;
      ferr_acc_q    <= 1'b0;
      pending_q     <= 1'b0;
      d_out_q       <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      stop_idx_q    <= stop_idx_d;
      shift_q       <= shift_d;
      par_acc_q     <= par_acc_d;
      perr_acc_q    <= perr_acc_d;
      ferr_acc_q    <= ferr_acc_d;
      pending_q     <= pending_d;
      d_out_q       <= d_out_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign d_out       = d_out_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: three receiver configurations (8N1, 7E2, 9O1) driven from frame-level stimulus.
module tb_uart_rx_param;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx_a, rx_b, rx_c;
  logic rd_ack_a, rd_ack_b, rd_ack_c;
  logic [7:0] d_out_a;
  logic [6:0] d_out_b;
  logic [8:0] d_out_c;
  logic rx_valid_a, rx_valid_b, rx_valid_c;
  logic parity_err_a, parity_err_b, parity_err_c;
  logic frame_err_a, frame_err_b, frame_err_c;
  logic overrun_err_a, overrun_err_b, overrun_err_c;
  logic busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .d_out(d_out_a), .rx_valid(rx_valid_a), .rd_ack(rd_ack_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun_err(overrun_err_a), .busy(busy_a));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .d_out(d_out_b), .rx_valid(rx_valid_b), .rd_ack(rd_ack_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun_err(overrun_err_b), .busy(busy_b));
  uart_rx_param #(.CLKS_PER_BIT(10), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(1)) u_dut_c (
    .clk(clk), .reset(reset), .rx(rx_c), .d_out(d_out_c), .rx_valid(rx_valid_c), .rd_ack(rd_ack_c),
    .parity_err(parity_err_c), .frame_err(frame_err_c), .overrun_err(overrun_err_c), .busy(busy_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int pend[3];
  logic last_busy_held;
  int   last_nq_held;
  logic [7:0] abort_word;

  typedef struct {
    logic [8:0] d;
    logic perr;
    logic ferr;
    logic oerr;
    int   cyc;
  } rec_t;

  typedef struct {
    int         inst;
    logic [8:0] word;
    bit         pflip;
    logic [1:0] stop_low;
    bit         ack;
    logic [8:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_oerr;
  } vec_t;

  rec_t q_a[$], q_b[$], q_c[$];
  vec_t vecs[12];

  function automatic rec_t mk_rec(input logic [8:0] d, input logic p, input logic f, input logic o);
    rec_t r;
    r.d = d; r.perr = p; r.ferr = f; r.oerr = o; r.cyc = cyc;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rx_valid_a) q_a.push_back(mk_rec({1'b0, d_out_a}, parity_err_a, frame_err_a, overrun_err_a));
    if (rx_valid_b) q_b.push_back(mk_rec({2'b00, d_out_b}, parity_err_b, frame_err_b, overrun_err_b));
    if (rx_valid_c) q_c.push_back(mk_rec(d_out_c, parity_err_c, frame_err_c, overrun_err_c));
  end

  function automatic int cfg_c(input int inst);
    return (inst == 2) ? 10 : 16;
  endfunction
  function automatic int cfg_db(input int inst);
    case (inst) 0: return 8; 1: return 7; default: return 9; endcase
  endfunction
  function automatic int cfg_pm(input int inst);
    case (inst) 0: return 0; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int cfg_sb(input int inst);
    return (inst == 1) ? 2 : 1;
  endfunction

  function automatic logic busy_of(input int inst);
    case (inst) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic int qsize(input int inst);
    case (inst) 0: return q_a.size(); 1: return q_b.size(); default: return q_c.size(); endcase
  endfunction

  task automatic set_rx(input int inst, input logic v);
    case (inst) 0: rx_a = v; 1: rx_b = v; default: rx_c = v; endcase
  endtask

  task automatic set_ack(input int inst, input logic v);
    case (inst) 0: rd_ack_a = v; 1: rd_ack_b = v; default: rd_ack_c = v; endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic pulse_ack(input int inst);
    @(posedge clk); #1;
    set_ack(inst, 1'b1);
    @(posedge clk); #1;
    set_ack(inst, 1'b0);
  endtask

  // Drives one frame; bit j of the frame is held for C clocks, position p of a bit is sampled at edge p+1.
  task automatic send_frame(input int inst, input logic [8:0] word, input bit pflip,
                            input logic [1:0] stop_low, input int glitch_j, input int hold_low,
                            output int t_first);
    int c, db, pm, sb, nb, g;
    logic fb[16];
    logic par;
    c = cfg_c(inst); db = cfg_db(inst); pm = cfg_pm(inst); sb = cfg_sb(inst);
    nb = 0;
    fb[nb] = 1'b0; nb++;
    par = 1'b0;
    for (int i = 0; i < db; i++) begin
      fb[nb] = word[i]; nb++;
      par = par ^ word[i];
    end
    if (pm != 0) begin
      fb[nb] = par ^ (pm == 2) ^ pflip; nb++;
    end
    for (int s = 0; s < sb; s++) begin
      fb[nb] = ~stop_low[s]; nb++;
    end
    g = c / 2 + 1;
    @(posedge clk); #1;
    t_first = cyc + 1;
    for (int j = 0; j < nb; j++) begin
      for (int p = 0; p < c; p++) begin
        set_rx(inst, (j == glitch_j && p == g) ? ~fb[j] : fb[j]);
        @(posedge clk); #1;
      end
    end
    if (hold_low > 0) begin
      set_rx(inst, 1'b0);
      repeat (hold_low) @(posedge clk);
      #1;
    end
    last_busy_held = busy_of(inst);
    last_nq_held   = qsize(inst);
    set_rx(inst, 1'b1);
    repeat (2 * c) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int inst, input int t_first, input logic [8:0] exp_d,
                             input logic exp_perr, input logic exp_ferr, input logic exp_oerr);
    rec_t r;
    int n, c, lat;
    c = cfg_c(inst);
    lat = 2 + c / 2 + (cfg_db(inst) + ((cfg_pm(inst) != 0) ? 1 : 0) + cfg_sb(inst)) * c + 1 + MAJ;
    n = 0;
    while (qsize(inst) == 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    if (qsize(inst) == 0) begin
      checks++; failures++;
      $display("FAIL %s.rx_valid: got none, want one within budget", tag);
      return;
    end
    case (inst) 0: r = q_a.pop_front(); 1: r = q_b.pop_front(); default: r = q_c.pop_front(); endcase
    chk({tag, ".d_out"}, 32'(r.d), 32'(exp_d));
    chk({tag, ".parity_err"}, 32'(r.perr), 32'(exp_perr));
    chk({tag, ".frame_err"}, 32'(r.ferr), 32'(exp_ferr));
    chk({tag, ".overrun_err"}, 32'(r.oerr), 32'(exp_oerr));
    chk({tag, ".latency"}, 32'(r.cyc - t_first), 32'(lat));
  endtask

  task automatic do_frame(input string tag, input int inst, input logic [8:0] word, input bit pflip,
                          input logic [1:0] stop_low, input bit ack, input int glitch_j, input int hold_low,
                          input logic [8:0] exp_d, input logic exp_perr, input logic exp_ferr,
                          input logic exp_oerr);
    int t;
    if (ack) begin
      pulse_ack(inst);
      pend[inst] = 0;
    end
    send_frame(inst, word, pflip, stop_low, glitch_j, hold_low, t);
    check_frame(tag, inst, t, exp_d, exp_perr, exp_ferr, exp_oerr);
    pend[inst] = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w, ed;
    logic [1:0] sl, sbmask;
    bit pf, ak;
    int inst, db, pm;

    vecs[0]  = '{0, 9'h0A5, 0, 2'b00, 1, 9'h0A5, 0, 0, 0};
    vecs[1]  = '{0, 9'h011, 0, 2'b00, 1, 9'h011, 0, 0, 0};
    vecs[2]  = '{0, 9'h022, 0, 2'b00, 0, 9'h022, 0, 0, 1};
    vecs[3]  = '{0, 9'h044, 0, 2'b00, 1, 9'h044, 0, 0, 0};
    vecs[4]  = '{0, 9'h081, 0, 2'b01, 1, 9'h081, 0, 1, 0};
    vecs[5]  = '{1, 9'h055, 0, 2'b00, 1, 9'h055, 0, 0, 0};
    vecs[6]  = '{1, 9'h055, 1, 2'b00, 1, 9'h055, 1, 0, 0};
    vecs[7]  = '{1, 9'h02A, 0, 2'b01, 1, 9'h02A, 0, 1, 0};
    vecs[8]  = '{1, 9'h07F, 1, 2'b10, 0, 9'h07F, 1, 1, 1};
    vecs[9]  = '{2, 9'h1A5, 0, 2'b00, 1, 9'h1A5, 0, 0, 0};
    vecs[10] = '{2, 9'h0FF, 1, 2'b00, 1, 9'h0FF, 1, 0, 0};
    vecs[11] = '{2, 9'h100, 0, 2'b00, 0, 9'h100, 0, 0, 1};

    reset = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rd_ack_a = 1'b0; rd_ack_b = 1'b0; rd_ack_c = 1'b0;
    for (int i = 0; i < 3; i++) pend[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.a", 32'({d_out_a, rx_valid_a, parity_err_a, frame_err_a, overrun_err_a, busy_a}), 32'd0);
    chk("reset.b", 32'({d_out_b, rx_valid_b, parity_err_b, frame_err_b, overrun_err_b, busy_b}), 32'd0);
    chk("reset.c", 32'({d_out_c, rx_valid_c, parity_err_c, frame_err_c, overrun_err_c, busy_c}), 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].inst, vecs[i].word, vecs[i].pflip, vecs[i].stop_low,
               vecs[i].ack, -1, 0, vecs[i].exp_d, vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_oerr);
    end

    // False start: 5 low cycles must be rejected at the start-bit centre.
    @(posedge clk); #1;
    rx_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_a = 1'b1;
    chk("glitch.busy_high", 32'(busy_a), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("glitch.busy_low", 32'(busy_a), 32'd0);
    chk("glitch.no_valid", 32'(qsize(0)), 32'd0);
    do_frame("after_glitch", 0, 9'h03C, 0, 2'b00, 1, -1, 0, 9'h03C, 0, 0, 0);

    // Break: low stop bit then line held low for 100 bit times.
    do_frame("break", 0, 9'h000, 0, 2'b01, 1, -1, 100 * 16, 9'h000, 0, 1, 0);
    chk("break.busy_held", 32'(last_busy_held), 32'd1);
    chk("break.single_valid", 32'(last_nq_held), 32'd1);
    chk("break.busy_after", 32'(busy_a), 32'd0);
    chk("break.no_extra", 32'(qsize(0)), 32'd0);

    // Reset in the middle of data bit 4 discards the partial word.
    abort_word = 8'h7E;
    @(posedge clk); #1;
    rx_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx_a = abort_word[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_a = abort_word[4];
    repeat (8) @(posedge clk);
    #1;
    chk("abort.busy_mid", 32'(busy_a), 32'd1);
    reset = 1'b0;
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.busy_rst", 32'(busy_a), 32'd0);
    chk("abort.d_out_rst", 32'(d_out_a), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) pend[i] = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort.no_valid", 32'(qsize(0)), 32'd0);
    do_frame("after_abort", 0, 9'h07E, 0, 2'b00, 0, -1, 0, 9'h07E, 0, 0, 0);

    // One-cycle inverted glitch at the centre of data bit 2.
`ifdef UART_RX_MAJORITY_EN
    do_frame("mid_glitch", 0, 9'h07E, 0, 2'b00, 1, 3, 0, 9'h07E, 0, 0, 0);
`else
    do_frame("mid_glitch", 0, 9'h07E, 0, 2'b00, 1, 3, 0, 9'h07A, 0, 0, 0);
`endif

    // Random frames against the frame-level model.
    for (int k = 0; k < 24; k++) begin
      inst = int'($urandom_range(0, 2));
      db = cfg_db(inst);
      pm = cfg_pm(inst);
      w  = 9'($urandom_range(0, 511));
      pf = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ak = 1'($urandom_range(0, 1));
      ed = w & 9'((1 << db) - 1);
      sbmask = (cfg_sb(inst) == 2) ? 2'b11 : 2'b01;
      do_frame($sformatf("rand%0d", k), inst, ed, pf, sl, ak, -1, 0, ed,
               pf && (pm != 0), |(sl & sbmask), ak ? 1'b0 : (pend[inst] != 0));
    end

    chk("end.q_a_empty", 32'(qsize(0)), 32'd0);
    chk("end.q_b_empty", 32'(qsize(1)), 32'd0);
    chk("end.q_c_empty", 32'(qsize(2)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
